// File: rtl/pcpi_shared_mem.sv
// Shared word memory arbitrated round-robin between NUM_PORTS PCPI-style masters.
// One access in flight; completion is a one-cycle mem_ready pulse on the granted port,
// LATENCY edges after the accept edge (the accept edge itself counts as the first).
// Optional feature macro: SHARED_MEM_BOUNDS_EN adds mem_err and rejects addresses
// >= DEPTH_WORDS*4; without it addresses wrap modulo the memory size.
module pcpi_shared_mem #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_PORTS-1:0]     mem_valid,
  output logic [NUM_PORTS-1:0]     mem_ready,
  input  logic [NUM_PORTS*32-1:0]  mem_addr,
  input  logic [NUM_PORTS*32-1:0]  mem_wdata,
  input  logic [NUM_PORTS*4-1:0]   mem_wstrb,
`ifdef SHARED_MEM_BOUNDS_EN
  output logic [NUM_PORTS-1:0]     mem_err,
`endif
  output logic [NUM_PORTS*32-1:0]  mem_rdata
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [PW-1:0]           last_grant_q;
  logic [PW-1:0]           port_q;
  logic [31:0]             addr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic [NUM_PORTS-1:0]    ready_q;
  logic [NUM_PORTS-1:0]    err_q;
  logic [NUM_PORTS*32-1:0] rdata_q;

  // Write port of the array is registered one edge behind the commit so that the
  // array itself needs no reset gating; the next commit is always >= 2 edges later.
  logic                    wr_en_q;
  logic [AW-1:0]           wr_idx_q;
  logic [31:0]             wr_data_q;
  logic [3:0]              wr_strb_q;

  logic [31:0]             mem [DEPTH_WORDS];

  logic                    gnt_found;
  logic [PW-1:0]           gnt_idx;
  logic [PW-1:0]           cand;
  logic [31:0]             live_addr;
  logic [31:0]             live_wdata;
  logic [3:0]              live_wstrb;

  logic                    accept;
  logic                    commit_live;
  logic                    commit_wait;
  logic                    commit;
  logic [PW-1:0]           c_port;
  logic [31:0]             c_addr;
  logic [31:0]             c_wdata;
  logic [3:0]              c_wstrb;
  logic [AW-1:0]           c_idx;
  logic                    c_oob;

  // Round-robin pick: first requesting port starting after the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = PW'((32'(last_grant_q) + k) % NUM_PORTS);
      if (!gnt_found && mem_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Request fields of the port that would be granted this cycle.
  always_comb begin
    live_addr  = '0;
    live_wdata = '0;
    live_wstrb = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (PW'(p) == gnt_idx) begin
        live_addr  = mem_addr[p*32 +: 32];
        live_wdata = mem_wdata[p*32 +: 32];
        live_wstrb = mem_wstrb[p*4 +: 4];
      end
    end
  end

  assign accept      = (state_q == StIdle) && gnt_found;
  // With LATENCY=1 the accept edge is also the commit edge, so use the live request.
  assign commit_live = accept && (LATENCY == 1);
  assign commit_wait = (state_q == StWait) && (cnt_q == 4'd1);
  assign commit      = commit_live || commit_wait;
  assign c_port      = commit_live ? gnt_idx    : port_q;
  assign c_addr      = commit_live ? live_addr  : addr_q;
  assign c_wdata     = commit_live ? live_wdata : wdata_q;
  assign c_wstrb     = commit_live ? live_wstrb : wstrb_q;
  assign c_idx       = c_addr[AW+1:2];

`ifdef SHARED_MEM_BOUNDS_EN
  assign c_oob   = (c_addr >= 32'(DEPTH_WORDS * 4));
  assign mem_err = err_q;
`else
  assign c_oob = 1'b0;
  logic unused_err;
  assign unused_err = ^err_q;
`endif

  // Only the word index is consumed; byte offset and (when wrapping) high bits are dropped.
  logic unused_addr;
  assign unused_addr = ^c_addr;

  // Control FSM with registered completion outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= PW'(NUM_PORTS - 1);
      port_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      ready_q      <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      wr_strb_q    <= '0;
    end else begin
      ready_q   <= '0;
      err_q     <= '0;
      wr_en_q   <= commit && !c_oob && (c_wstrb != 4'h0);
      wr_idx_q  <= c_idx;
      wr_data_q <= c_wdata;
      wr_strb_q <= c_wstrb;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            last_grant_q <= gnt_idx;
            port_q       <= gnt_idx;
            addr_q       <= live_addr;
            wdata_q      <= live_wdata;
            wstrb_q      <= live_wstrb;
            cnt_q        <= CntLoad;
            state_q      <= (LATENCY == 1) ? StResp : StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            cnt_q   <= '0;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (commit) begin
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
          if (PW'(p) == c_port) begin
            ready_q[p]          <= 1'b1;
            err_q[p]            <= c_oob;
            rdata_q[p*32 +: 32] <= c_oob ? 32'h0 : mem[c_idx];
          end
        end
      end
    end
  end

  // Byte-enabled array write, one edge after the commit; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb_q[i]) mem[wr_idx_q][i*8 +: 8] <= wr_data_q[i*8 +: 8];
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;

endmodule
